// File: rtl/pid_channel_scheduler.sv
// Round-robin scheduler that time-shares one PID core between NCH channels.
// Optional WAIT watchdog enabled by defining PID_SCHED_TIMEOUT_EN.
module pid_channel_scheduler #(
    parameter int NCH      = 4,
    parameter int DW       = 8,
    parameter int TICK_DIV = 100,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         ch_req,
    input  logic [NCH*DW-1:0]      ch_setpoint,
    input  logic [NCH*DW-1:0]      ch_feedback,
    output logic                   pid_start,
    output logic [$clog2(NCH)-1:0] pid_ch,
    output logic [DW-1:0]          pid_setpoint,
    output logic [DW-1:0]          pid_feedback,
    input  logic                   pid_done,
    input  logic [DW-1:0]          pid_result,
    output logic [NCH*DW-1:0]      ch_out,
    output logic [NCH-1:0]         ch_out_valid,
    output logic                   busy,
    output logic [NCH-1:0]         ovr,
    output logic                   err
);

    localparam int CW  = $clog2(NCH);
    localparam int TCW = $clog2(TICK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    if (NCH < 2 || TICK_DIV < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("pid_channel_scheduler: NCH, TICK_DIV and TIMEOUT must be >= 2");
    end

    logic [1:0]     state;
    logic [TCW-1:0] tick_cnt;
    logic           tick;
    logic [NCH-1:0] pending;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  grant;
    logic           grant_vld;
    logic           timeout;
    logic           release_ch;
    logic [NCH-1:0] clr_mask;
    logic [NCH-1:0] set_mask;

    assign tick = (tick_cnt == TCW'(TICK_DIV - 1));

    // NOTE: sequential state is always updated with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        // Scan downwards so the smallest offset from rr_ptr is the last writer.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pending[rr_ptr + CW'(k)]) begin
                grant     = rr_ptr + CW'(k);
                grant_vld = 1'b1;
            end
        end
    end

`ifdef PID_SCHED_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT);
    logic [WCW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A done arriving on the last allowed cycle wins over the watchdog.
    assign timeout = (state == S_WAIT) && (wait_cnt == WCW'(TIMEOUT - 1)) && !pid_done;
`else
    assign timeout = 1'b0;
`endif

    assign release_ch = (state == S_WRITE) || timeout;
    assign clr_mask   = release_ch ? (NCH'(1) << pid_ch) : '0;
    assign set_mask   = tick ? ch_req : '0;

    // A tick landing on an already pending channel is an overrun, even when the
    // same cycle retires it: the new request survives, so a sample was merged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            ovr     <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
            ovr     <= ovr | (set_mask & pending);
            if (release_ch) begin
                rr_ptr <= pid_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pid_ch       <= '0;
            pid_setpoint <= '0;
            pid_feedback <= '0;
            ch_out       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        pid_ch       <= grant;
                        pid_setpoint <= ch_setpoint[int'(grant)*DW +: DW];
                        pid_feedback <= ch_feedback[int'(grant)*DW +: DW];
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (pid_done) begin
                        ch_out[int'(pid_ch)*DW +: DW] <= pid_result;
                        state                         <= S_WRITE;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pid_start    = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);
    assign ch_out_valid = (state == S_WRITE) ? (NCH'(1) << pid_ch) : '0;
    assign err          = timeout;

endmodule
